// File: rtl/dmem_unit.sv
// dmem_unit: synchronous 64-bit data memory behind the CPU data port.
// The CPU port serves one-cycle-latency loads and stores. A host port with a
// 4-phase req/ack handshake preloads and dumps the array during idle CPU
// cycles.
// Optional feature macro: DMEM_STATS_EN. When it is defined, the unit adds
// saturating 16-bit CPU load/store counters (ld_count, st_count).
//
// Handshake (host side): the host raises host_req with host_wr/host_addr/
// host_wdata stable. The unit performs the access on an edge where the CPU is
// idle and pulses host_ack for exactly one cycle. host_rdata is valid with
// host_ack and holds afterwards. The host must then drop host_req before the
// unit accepts another request.
module dmem_unit #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_en,
  input  logic              mem_sl,
  input  logic [63:0]       st_data,
  output logic [63:0]       ld_data,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [63:0]       host_wdata,
  output logic              host_ack,
  output logic [63:0]       host_rdata,
  output logic              addr_err,
`ifdef DMEM_STATS_EN
  output logic [15:0]       ld_count,
  output logic [15:0]       st_count,
`endif
  output logic [1:0]        host_state_dbg
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_RELEASE = 2'd2
  } host_state_t;

  host_state_t state_q;
  host_state_t state_d;

  logic [63:0] mem [DEPTH];

  logic             cpu_in_range;
  logic             host_in_range;
  logic [IDX_W-1:0] cpu_idx;
  logic [IDX_W-1:0] host_idx;
  logic             cpu_load;
  logic             cpu_store;
  logic             host_take;

  assign cpu_in_range  = (mem_addr  < ADDR_W'(DEPTH));
  assign host_in_range = (host_addr < ADDR_W'(DEPTH));
  assign cpu_idx       = mem_addr[IDX_W-1:0];
  assign host_idx      = host_addr[IDX_W-1:0];
  assign cpu_load      = mem_en && !mem_sl;
  assign cpu_store     = mem_en &&  mem_sl;
  // The host only gets the array on an edge the CPU leaves idle.
  assign host_take     = (state_q == ST_IDLE) && host_req && !mem_en;

  // Array writes: CPU stores first, host writes only on CPU-idle edges.
  // Out-of-range writes are dropped. Reset is not applied to the array.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (cpu_store && cpu_in_range) begin
        mem[cpu_idx] <= st_data;
      end else if (host_take && host_wr && host_in_range) begin
        mem[host_idx] <= host_wdata;
      end
    end
  end

  // CPU load result register: updates only on a load edge, holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_data <= '0;
    end else if (cpu_load) begin
      ld_data <= cpu_in_range ? mem[cpu_idx] : 64'h0;
    end
  end

  // Host read data capture on the access edge of a read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_rdata <= '0;
    end else if (host_take && !host_wr) begin
      host_rdata <= host_in_range ? mem[host_idx] : 64'h0;
    end
  end

  // Sticky out-of-range flag for either port; cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_err <= 1'b0;
    end else if ((mem_en && !cpu_in_range) || (host_take && !host_in_range)) begin
      addr_err <= 1'b1;
    end
  end

  // Host FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Host FSM next state: access, one ACK cycle, then wait for req to drop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (host_take) state_d = ST_ACK;
      ST_ACK:     state_d = ST_RELEASE;
      ST_RELEASE: if (!host_req) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // host_ack decodes the state register only, so it has no input path.
  assign host_ack       = (state_q == ST_ACK);
  assign host_state_dbg = state_q;

`ifdef DMEM_STATS_EN
  // Saturating CPU access counters; out-of-range accesses are counted too.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_count <= '0;
      st_count <= '0;
    end else begin
      if (cpu_load && (ld_count != 16'hFFFF)) begin
        ld_count <= ld_count + 16'd1;
      end
      if (cpu_store && (st_count != 16'hFFFF)) begin
        st_count <= st_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: directed test of dmem_unit. Inputs change on the falling
// edge; outputs are compared on the falling edge after the active rising edge.
module tb_dmem_unit;

  logic        clk;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic        mem_sl;
  logic [63:0] st_data;
  logic [63:0] ld_data;
  logic        host_req;
  logic        host_wr;
  logic [15:0] host_addr;
  logic [63:0] host_wdata;
  logic        host_ack;
  logic [63:0] host_rdata;
  logic        addr_err;
  logic [1:0]  host_state_dbg;
`ifdef DMEM_STATS_EN
  logic [15:0] ld_count;
  logic [15:0] st_count;
`endif

  int n_vec;
  int n_miss;

  dmem_unit #(.DEPTH(256), .ADDR_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_en         (mem_en),
    .mem_sl         (mem_sl),
    .st_data        (st_data),
    .ld_data        (ld_data),
    .host_req       (host_req),
    .host_wr        (host_wr),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_ack       (host_ack),
    .host_rdata     (host_rdata),
    .addr_err       (addr_err),
`ifdef DMEM_STATS_EN
    .ld_count       (ld_count),
    .st_count       (st_count),
`endif
    .host_state_dbg (host_state_dbg)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    mem_en = 1'b0;
  endtask

  // Issue one CPU access across the next rising edge.
  task automatic cpu_op(input logic sl, input logic [15:0] a, input logic [63:0] d);
    @(negedge clk);
    mem_en   = 1'b1;
    mem_sl   = sl;
    mem_addr = a;
    st_data  = d;
    @(negedge clk);
    mem_en   = 1'b0;
  endtask

  // Full host handshake with a bounded wait for host_ack.
  task automatic host_xfer(input string tag, input logic wr, input logic [15:0] a,
                           input logic [63:0] d, output logic [63:0] rd);
    logic got_ack;
    got_ack = 1'b0;
    @(negedge clk);
    host_req   = 1'b1;
    host_wr    = wr;
    host_addr  = a;
    host_wdata = d;
    for (int i = 0; i < 20 && !got_ack; i++) begin
      @(negedge clk);
      if (host_ack) got_ack = 1'b1;
    end
    rd = host_rdata;
    check({tag, "_ack_seen"}, {63'd0, got_ack}, 64'd1);
    host_req = 1'b0;
    @(negedge clk);
  endtask

  logic [63:0] rd;

  // Directed stimulus sequence
  initial begin
    n_vec      = 0;
    n_miss     = 0;
    reset      = 1'b0;
    mem_addr   = '0;
    mem_en     = 1'b0;
    mem_sl     = 1'b0;
    st_data    = '0;
    host_req   = 1'b1;
    host_wr    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;

    // Reset asserted with host_req high: outputs cleared without a clock edge.
    #3;
    check("rst_ld_data",    ld_data,           64'h0);
    check("rst_host_ack",   {63'd0, host_ack}, 64'h0);
    check("rst_addr_err",   {63'd0, addr_err}, 64'h0);
    check("rst_host_rdata", host_rdata,        64'h0);
    host_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Host preload of addr 5 with an explicit one-cycle ack pulse check.
    host_req   = 1'b1;
    host_wr    = 1'b1;
    host_addr  = 16'd5;
    host_wdata = 64'hDEADBEEF_00000001;
    @(negedge clk);
    check("hw5_ack_hi",   {63'd0, host_ack}, 64'd1);
    @(negedge clk);
    check("hw5_ack_lo_1", {63'd0, host_ack}, 64'd0);
    @(negedge clk);
    check("hw5_ack_lo_2", {63'd0, host_ack}, 64'd0);
    host_req = 1'b0;
    @(negedge clk);

    // CPU load of addr 5, then held through three idle cycles.
    cpu_op(1'b0, 16'd5, 64'h0);
    check("ld5", ld_data, 64'hDEADBEEF_00000001);
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      check("ld5_hold", ld_data, 64'hDEADBEEF_00000001);
    end

    // Store then load on consecutive edges.
    @(negedge clk);
    mem_en = 1'b1; mem_sl = 1'b1; mem_addr = 16'd7; st_data = 64'h1234;
    @(negedge clk);
    check("st7_ld_unchanged", ld_data, 64'hDEADBEEF_00000001);
    mem_sl = 1'b0;
    @(negedge clk);
    mem_en = 1'b0;
    check("ld7_b2b", ld_data, 64'h1234);

    // Arbitration: CPU busy for 4 edges stalls a host read of addr 7.
    mem_en = 1'b1; mem_sl = 1'b0; mem_addr = 16'd5;
    host_req = 1'b1; host_wr = 1'b0; host_addr = 16'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("arb_stall_ack", {63'd0, host_ack}, 64'd0);
    end
    mem_en = 1'b0;
    @(negedge clk);
    check("arb_ack_after", {63'd0, host_ack}, 64'd1);
    check("arb_rdata",     host_rdata,        64'h1234);
    check("arb_cpu_data",  ld_data,           64'hDEADBEEF_00000001);
    @(negedge clk);
    check("arb_ack_drop",  {63'd0, host_ack}, 64'd0);
    host_req = 1'b0;
    @(negedge clk);

    // Out of range: preload addr 0 and alias addr 44, then store/load addr 300.
    host_xfer("hw0",  1'b1, 16'd0,  64'hA0A0_0000_0000_0000, rd);
    host_xfer("hw44", 1'b1, 16'd44, 64'h4444_4444_4444_4444, rd);
    check("oor_err_before", {63'd0, addr_err}, 64'd0);
    cpu_op(1'b1, 16'd300, 64'hBAD0_BAD0_BAD0_BAD0);
    check("oor_err_after_st", {63'd0, addr_err}, 64'd1);
    cpu_op(1'b0, 16'd300, 64'h0);
    check("oor_ld_zero", ld_data, 64'h0);
    check("oor_err_sticky", {63'd0, addr_err}, 64'd1);
    host_xfer("hr0",  1'b0, 16'd0,  64'h0, rd);
    check("oor_hr0_intact", rd, 64'hA0A0_0000_0000_0000);
    host_xfer("hr44", 1'b0, 16'd44, 64'h0, rd);
    check("oor_hr44_intact", rd, 64'h4444_4444_4444_4444);
    host_xfer("hr300", 1'b0, 16'd300, 64'h0, rd);
    check("oor_hr300_zero", rd, 64'h0);

    // Reset mid-handshake while host_ack is high.
    @(negedge clk);
    host_req = 1'b1; host_wr = 1'b1; host_addr = 16'd9; host_wdata = 64'h99;
    @(negedge clk);
    check("mid_ack_hi", {63'd0, host_ack}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_ack",      {63'd0, host_ack}, 64'd0);
    check("mid_rst_ld_data",  ld_data,           64'h0);
    check("mid_rst_addr_err", {63'd0, addr_err}, 64'd0);
    check("mid_rst_rdata",    host_rdata,        64'h0);
    host_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ack", {63'd0, host_ack}, 64'd0);
    host_xfer("hr7_post", 1'b0, 16'd7, 64'h0, rd);
    check("post_rst_mem7", rd, 64'h1234);

`ifdef DMEM_STATS_EN
    check("stats_ld_zero", {48'd0, ld_count}, 64'd0);
    cpu_op(1'b0, 16'd5, 64'h0);
    cpu_op(1'b1, 16'd8, 64'h8);
    cpu_op(1'b0, 16'd7, 64'h0);
    cpu_op(1'b1, 16'd400, 64'h1);
    cpu_op(1'b0, 16'd500, 64'h0);
    check("stats_ld3", {48'd0, ld_count}, 64'd3);
    check("stats_st2", {48'd0, st_count}, 64'd2);
    @(negedge clk);
    mem_en = 1'b1; mem_sl = 1'b0; mem_addr = 16'd5;
    for (int i = 0; i < 70000; i++) @(negedge clk);
    mem_en = 1'b0;
    check("stats_ld_sat", {48'd0, ld_count}, 64'hFFFF);
    check("stats_st_hold", {48'd0, st_count}, 64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
